// File: rtl/shift_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_frame_sequencer
//  Brief    : Upstream control stage for universal_shift_register. Accepts
//             whole frames (SIZE words of WIDTH bits) over valid/ready,
//             drives the register's ce/load/dir/din, and presents a
//             word-level valid/last/ready stream aligned to its data_out.
//  Options  : SHIFT_SEQ_PREFETCH_EN - adds a one-frame prefetch slot so a
//             queued frame loads straight after the final word (no IDLE gap).
//  Revision : 1.0 - initial release
// ============================================================================
module shift_frame_sequencer #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 3,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [WIDTH*SIZE-1:0]   frame_data,
    input  logic                    frame_dir,
    input  logic                    flush,
    output logic                    sr_ce,
    output logic                    sr_load,
    output logic                    sr_dir,
    output logic [WIDTH*SIZE-1:0]   sr_din,
    output logic                    word_valid,
    output logic                    word_last,
    input  logic                    word_ready,
    output logic [CNT_W-1:0]        frames_done
);

    // Word counter width; a single-bit counter is kept even for degenerate sizes.
    localparam int c_CNT_BITS = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [c_CNT_BITS-1:0] c_LAST_CNT = c_CNT_BITS'(SIZE - 1);
    localparam logic [c_CNT_BITS-1:0] c_CNT_ONE  = c_CNT_BITS'(1);
    localparam logic [CNT_W-1:0]      c_DONE_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_CNT_BITS-1:0]   r_cnt;
    logic [CNT_W-1:0]        r_frames_done;
    logic [WIDTH*SIZE-1:0]   r_frame;
    logic                    r_dir;

`ifdef SHIFT_SEQ_PREFETCH_EN
    logic                    r_slot_full;
    logic [WIDTH*SIZE-1:0]   r_slot_frame;
    logic                    r_slot_dir;
`endif

    logic                    w_last;
    logic                    w_accept;

    assign w_last   = (r_cnt == c_LAST_CNT);
    // frame_ready already folds in rst and flush, so this is a true handshake.
    assign w_accept = frame_valid && frame_ready;

    // Sequencer state: frame capture, load/shift progression and frame counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_frames_done <= '0;
            r_frame       <= '0;
            r_dir         <= 1'b0;
`ifdef SHIFT_SEQ_PREFETCH_EN
            r_slot_full   <= 1'b0;
            r_slot_frame  <= '0;
            r_slot_dir    <= 1'b0;
`endif
        end else if (flush) begin
            // Abort: hold regs keep their contents, the frame is not counted.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`ifdef SHIFT_SEQ_PREFETCH_EN
            r_slot_full <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_frame <= frame_data;
                        r_dir   <= frame_dir;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= ST_SHIFT;
`ifdef SHIFT_SEQ_PREFETCH_EN
                    if (w_accept) begin
                        r_slot_full  <= 1'b1;
                        r_slot_frame <= frame_data;
                        r_slot_dir   <= frame_dir;
                    end
`endif
                end
                ST_SHIFT: begin
                    if (word_ready) begin
                        if (w_last) begin
                            r_frames_done <= r_frames_done + c_DONE_ONE;
                            r_cnt         <= '0;
                            r_state       <= ST_IDLE;
`ifdef SHIFT_SEQ_PREFETCH_EN
                            // Chain the next frame directly into LOAD.
                            if (r_slot_full) begin
                                r_frame     <= r_slot_frame;
                                r_dir       <= r_slot_dir;
                                r_slot_full <= 1'b0;
                                r_state     <= ST_LOAD;
                            end else if (w_accept) begin
                                r_frame <= frame_data;
                                r_dir   <= frame_dir;
                                r_state <= ST_LOAD;
                            end
`endif
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
`ifdef SHIFT_SEQ_PREFETCH_EN
                    // A frame arriving on the final word bypasses the slot.
                    if (w_accept && !(word_ready && w_last)) begin
                        r_slot_full  <= 1'b1;
                        r_slot_frame <= frame_data;
                        r_slot_dir   <= frame_dir;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode: everything forced low while rst is asserted.
    always_comb begin
        frame_ready = 1'b0;
        sr_ce       = 1'b0;
        sr_load     = 1'b0;
        sr_dir      = 1'b0;
        sr_din      = '0;
        word_valid  = 1'b0;
        word_last   = 1'b0;
        frames_done = '0;
        if (!rst) begin
`ifdef SHIFT_SEQ_PREFETCH_EN
            frame_ready = !flush && !r_slot_full;
`else
            frame_ready = !flush && (r_state == ST_IDLE);
`endif
            sr_dir      = r_dir;
            sr_din      = r_frame;
            frames_done = r_frames_done;
            case (r_state)
                ST_LOAD: begin
                    sr_load = 1'b1;
                    sr_ce   = !flush;
                end
                ST_SHIFT: begin
                    word_valid = 1'b1;
                    word_last  = w_last;
                    // Withholding ce freezes data_out while downstream stalls.
                    sr_ce      = word_ready && !flush;
                end
                default: begin
                    sr_ce = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_frame_sequencer
//  Brief    : Self-checking bench for shift_frame_sequencer (default build).
//             A frame-level model predicts every output each cycle; literal
//             checks pin the model to hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_frame_sequencer;

    localparam int WIDTH = 4;
    localparam int SIZE  = 3;
    localparam int CNT_W = 8;
    localparam int FW    = WIDTH * SIZE;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_valid;
    logic              frame_ready;
    logic [FW-1:0]     frame_data;
    logic              frame_dir;
    logic              flush;
    logic              sr_ce;
    logic              sr_load;
    logic              sr_dir;
    logic [FW-1:0]     sr_din;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;
    logic [CNT_W-1:0]  frames_done;

    always #5 clk = ~clk;

    shift_frame_sequencer #(.WIDTH(WIDTH), .SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_dir   (frame_dir),
        .flush       (flush),
        .sr_ce       (sr_ce),
        .sr_load     (sr_load),
        .sr_dir      (sr_dir),
        .sr_din      (sr_din),
        .word_valid  (word_valid),
        .word_last   (word_last),
        .word_ready  (word_ready),
        .frames_done (frames_done)
    );

    int errors  = 0;
    int checks  = 0;
    int ce_seen = 0;

    // Frame-level model: a frame is either waiting for its load cycle, or
    // being emitted word by word; otherwise the sequencer is free.
    bit            m_loading  = 1'b0;
    bit            m_shifting = 1'b0;
    int            m_word     = 0;
    logic [FW-1:0] m_frame    = '0;
    logic          m_dir      = 1'b0;
    int            m_done     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit live;
        bit idle;
        live = (rst !== 1'b1);
        idle = !m_loading && !m_shifting;
        chk("frame_ready", frame_ready, live && !flush && idle);
        chk("sr_ce",       sr_ce,       live && !flush && (m_loading || (m_shifting && word_ready)));
        chk("sr_load",     sr_load,     live && m_loading);
        chk("word_valid",  word_valid,  live && m_shifting);
        chk("word_last",   word_last,   live && m_shifting && (m_word == SIZE - 1));
        chk("sr_dir",      sr_dir,      live ? m_dir : 1'b0);
        chk("sr_din",      sr_din,      live ? m_frame : '0);
        chk("frames_done", frames_done, live ? (m_done % (1 << CNT_W)) : 0);
        if (sr_ce === 1'b1) ce_seen++;
    endtask

    task automatic model_step();
        if (rst) begin
            m_loading = 0; m_shifting = 0; m_word = 0;
            m_frame = '0; m_dir = 0; m_done = 0;
        end else if (flush) begin
            m_loading = 0; m_shifting = 0; m_word = 0;
        end else if (m_loading) begin
            m_loading = 0; m_shifting = 1; m_word = 0;
        end else if (m_shifting) begin
            if (word_ready) begin
                if (m_word == SIZE - 1) begin
                    m_shifting = 0; m_word = 0; m_done++;
                end else begin
                    m_word++;
                end
            end
        end else if (frame_valid) begin
            m_frame = frame_data; m_dir = frame_dir; m_loading = 1;
        end
    endtask

    // One clock: compare mid-low-phase, advance the model on the edge.
    task automatic tick();
        #2;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [FW-1:0] data, input logic dir);
        frame_valid = 1'b1; frame_data = data; frame_dir = dir; word_ready = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int i = 0; i < SIZE + 1; i++) tick();
    endtask

    initial begin
        rst = 1'b1; frame_valid = 1'b0; frame_data = '0; frame_dir = 1'b0;
        flush = 1'b0; word_ready = 1'b0;
        @(negedge clk);

        // Reset
        #1 chk("rst_ready", frame_ready, 0);
        chk("rst_done", frames_done, 0);
        tick(); tick();
        rst = 1'b0;
        #1 chk("idle_ready", frame_ready, 1);
        tick();

        // Basic frame
        frame_valid = 1'b1; frame_data = 12'habc; frame_dir = 1'b0; word_ready = 1'b1;
        tick();
        frame_valid = 1'b0; ce_seen = 0;
        #1 chk("basic_load", sr_load, 1);
        chk("basic_din", sr_din, 12'habc);
        tick();
        tick(); tick();
        #1 chk("basic_last", word_last, 1);
        tick();
        #1 chk("basic_done", frames_done, 1);
        chk("basic_ce_cycles", ce_seen, 4);
        chk("basic_ready_back", frame_ready, 1);
        chk("basic_valid_off", word_valid, 0);

        // Backpressure at cnt=1
        frame_valid = 1'b1; frame_data = 12'h5a3; tick();
        frame_valid = 1'b0;
        tick(); tick();
        word_ready = 1'b0;
        #1 chk("bp_ce", sr_ce, 0);
        chk("bp_valid", word_valid, 1);
        chk("bp_last", word_last, 0);
        tick(); tick();
        word_ready = 1'b1;
        #1 chk("bp_ce_resume", sr_ce, 1);
        tick();
        #1 chk("bp_last2", word_last, 1);
        tick();
        #1 chk("bp_done", frames_done, 2);

        // Direction
        frame_valid = 1'b1; frame_data = 12'hdef; frame_dir = 1'b1; tick();
        frame_valid = 1'b0;
        #1 chk("dir_load", sr_dir, 1);
        chk("dir_load_din", sr_din, 12'hdef);
        tick(); tick(); tick();
        #1 chk("dir_last", sr_dir, 1);
        chk("dir_last_din", sr_din, 12'hdef);
        tick();
        #1 chk("dir_done", frames_done, 3);

        // Flush at cnt=1
        frame_valid = 1'b1; frame_data = 12'h777; frame_dir = 1'b0; tick();
        frame_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        #1 chk("flush_ce", sr_ce, 0);
        chk("flush_ready", frame_ready, 0);
        tick();
        flush = 1'b0;
        #1 chk("flush_idle_ready", frame_ready, 1);
        chk("flush_valid", word_valid, 0);
        chk("flush_done", frames_done, 3);
        chk("flush_hold", sr_din, 12'h777);
        tick();
        run_frame(12'h123, 1'b0);
        #1 chk("post_flush_done", frames_done, 4);

        // Reset mid-SHIFT
        frame_valid = 1'b1; frame_data = 12'h456; tick();
        frame_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1 chk("rst_mid_valid", word_valid, 0);
        chk("rst_mid_din", sr_din, 0);
        chk("rst_mid_ce", sr_ce, 0);
        tick();
        rst = 1'b0;
        #1 chk("rst_mid_done", frames_done, 0);
        chk("rst_mid_ready", frame_ready, 1);
        tick();
        run_frame(12'h9c1, 1'b1);
        #1 chk("post_rst_done", frames_done, 1);

        // flush beats a handshake in IDLE; word_ready ignored in IDLE
        flush = 1'b1; frame_valid = 1'b1; frame_data = 12'h0ff; tick();
        flush = 1'b0; frame_valid = 1'b0; word_ready = 1'b0;
        #1 chk("flush_vs_hs", sr_load, 0);
        tick();
        word_ready = 1'b1; tick();

        // Back-to-back offers (period SIZE+2) followed by a mixed stimulus run
        frame_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            frame_data = FW'(12'h300 + i); tick();
        end
        for (int i = 0; i < 200; i++) begin
            frame_valid = 1'($urandom_range(0, 1));
            frame_data  = FW'($urandom);
            frame_dir   = 1'($urandom_range(0, 1));
            word_ready  = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            tick();
        end

        // frames_done wraps modulo 2^CNT_W
        flush = 1'b0; frame_valid = 1'b1; word_ready = 1'b1;
        for (int i = 0; i < 3000 && (m_done % (1 << CNT_W)) != 0; i++) tick();
        #1 chk("wrap_done", frames_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_frame_sequencer.md
Name: shift_frame_sequencer

Overview:
- Upstream control stage for universal_shift_register. Accepts whole frames (SIZE words of WIDTH bits) over a valid/ready handshake.
- Generates the register's ce/load/dir/din controls and a word-level valid/last/ready stream aligned to the register's data_out.
- Replaces hand-timed load/ce pulses with a counted, back-pressurable load-then-shift sequence.

Parameters:
- WIDTH, 4, bits per word; must match the shift register.
- SIZE, 3, words per frame (>=2); must match the shift register.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- frame_valid  input  1  upstream frame offered
- frame_ready  output  1  sequencer can accept a frame
- frame_data  input  WIDTH*SIZE  frame payload
- frame_dir  input  1  shift direction for this frame, sampled with frame_data
- flush  input  1  synchronous abort of the current frame
- sr_ce  output  1  to shift register ce
- sr_load  output  1  to shift register load
- sr_dir  output  1  to shift register dir
- sr_din  output  WIDTH*SIZE  to shift register din
- word_valid  output  1  shift register data_out holds a valid word
- word_last  output  1  current word is word SIZE-1 of the frame
- word_ready  input  1  downstream consumes the current word
- frames_done  output  CNT_W  count of fully shifted frames, wraps

Behaviour:
- FSM states: IDLE, LOAD, SHIFT. Word counter cnt is $clog2(SIZE) bits wide.
- Reset (rst=1 at a clk edge):
  - state=IDLE, cnt=0, frames_done=0, held frame and held dir cleared.
  - All outputs are 0 while rst is high, including frame_ready.
- IDLE:
  - frame_ready=1.
  - On frame_valid&&frame_ready, frame_data and frame_dir are registered into hold regs; next state LOAD.
- LOAD (exactly 1 cycle):
  - sr_ce=1, sr_load=1, word_valid=0.
  - Next state SHIFT with cnt=0.
- SHIFT:
  - word_valid=1; word_last=(cnt==SIZE-1).
  - sr_ce=word_ready and sr_load=0 (combinational).
  - On word_ready: cnt increments. If word_last, frames_done increments (mod 2^CNT_W), cnt returns to 0, and next state is IDLE.
  - On !word_ready: all state holds and sr_ce=0, so data_out is frozen.
- Static outputs:
  - sr_din = held frame and sr_dir = held dir in every state. They are stable from LOAD through the final shift.
  - frame_ready=0 in LOAD and SHIFT.
- Latency and throughput:
  - Handshake at edge N gives LOAD in cycle N+1 and first word_valid in cycle N+2.
  - Minimum frame period is SIZE+2 cycles.
- flush:
  - Sampled in any state; forces next state IDLE with cnt=0. frames_done is not incremented and the hold regs are kept.
  - sr_ce=0 in the flush cycle.
  - flush has priority over a frame handshake in the same cycle: frame_ready=0 when flush=1.
- rst overrides flush and every other input.
- word_ready is ignored outside SHIFT. frame_valid may drop without penalty while frame_ready=0.

Optional Feature:
- Macro: SHIFT_SEQ_PREFETCH_EN.
- Defined:
  - A second hold register (prefetch slot) is added. frame_ready = !slot_full in every non-reset state.
  - A frame accepted during LOAD/SHIFT fills the slot.
  - On the final accepted word, if the slot is full, the next state is LOAD with the slot moved into the hold regs. This removes the IDLE cycle, so the period becomes SIZE+1.
  - flush also empties the slot.
- Undefined: behaviour exactly as above.

Test Plan:
- Basic frame (WIDTH=4, SIZE=3): frame_data=12'habc, frame_dir=0, word_ready=1.
  - Response: one LOAD cycle with sr_load=1, sr_din=12'habc; then word_valid for 3 cycles with word_last on the 3rd.
  - sr_ce high for 4 consecutive cycles; frames_done 0->1; frame_ready back to 1 the next cycle.
- Backpressure: word_ready=0 for 2 cycles at cnt=1.
  - Response: sr_ce=0 and word_valid=1 hold for those cycles; cnt stays 1; frame still completes after 3 accepted words.
- Direction: frame_data=12'hdef with frame_dir=1.
  - Response: sr_dir=1 from LOAD through the last shift; sr_din=12'hdef throughout.
- Flush: flush=1 at cnt=1.
  - Response: next cycle state is IDLE with frame_ready=1 and word_valid=0; frames_done unchanged; a new 12'h123 frame then runs normally.
- Reset mid-SHIFT: rst=1 for 1 cycle.
  - Response: all outputs 0 during rst; frames_done=0; IDLE afterwards, ready for the next frame.
- Prefetch, with SHIFT_SEQ_PREFETCH_EN defined: two frames offered back-to-back.
  - Response: second frame accepted during SHIFT; its LOAD follows the first frame's word_last directly; 2 frames complete in 8 cycles.
